// File: rtl/pipeline_run_controller.sv
// Run/step sequencer for the MIPS stage registers: generates the shared start and step enables,
// stops on halt-in-write-back or advance budget expiry, and counts pipeline advances.
module pipeline_run_controller #(
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned MAX_CYCLES = 1024
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_mode,
    input  logic                 i_run_cmd,
    input  logic                 i_step_cmd,
    input  logic                 i_halt_wb,
    input  logic                 i_clear,
    output logic                 o_start,
    output logic                 o_step,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic [CNT_WIDTH-1:0] o_cycle_count,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StRun       = 3'd1,
        StStepWait  = 3'd2,
        StStepPulse = 3'd3,
        StDone      = 3'd4
    } state_e;

    localparam logic [CNT_WIDTH-1:0] LastCount = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CountSat  = '1;
    localparam logic [CNT_WIDTH-1:0] CountOne  = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic                 step_prev_q;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 step_rise;
    logic                 budget_hit;

    assign step_rise  = i_step_cmd & ~step_prev_q;
    assign budget_hit = (count_q == LastCount);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q     <= StIdle;
            step_prev_q <= 1'b0;
            timeout_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            step_prev_q <= i_step_cmd;
            timeout_q   <= timeout_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout_q;
        count_d   = count_q;

        // Every cycle with o_step high is an advance, including the one that detects the stop.
        if (o_step && (count_q != CountSat)) begin
            count_d = count_q + CountOne;
        end

        if (i_clear) begin
            state_d   = StIdle;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_run_cmd) begin
                        state_d = i_mode ? StStepWait : StRun;
                        count_d = '0;
                    end
                end
                StRun, StStepPulse: begin
                    if (i_halt_wb) begin
                        state_d = StDone;
                    end else if (budget_hit) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                    end else if (state_q == StStepPulse) begin
                        state_d = StStepWait;
                    end
                end
                StStepWait: begin
                    if (i_halt_wb) begin
                        state_d = StDone;
                    end else if (step_rise) begin
                        state_d = StStepPulse;
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign o_start       = (state_q == StRun) || (state_q == StStepWait) ||
                           (state_q == StStepPulse);
    assign o_step        = (state_q == StRun) || (state_q == StStepPulse);
    assign o_busy        = o_start;
    assign o_done        = (state_q == StDone);
    assign o_timeout     = timeout_q;
    assign o_cycle_count = count_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Bench for pipeline_run_controller: three configurations driven in lockstep and checked against
// a phase-flag reference model, plus directed sequences and a per-cycle vector table.
module tb_pipeline_run_controller;

    logic clk;
    logic rst_n, mode, run_cmd, step_cmd, halt, clr;

    // a: wide counter, roomy budget; b: budget 8; c: budget 8 with a 3-bit saturating counter
    logic        a_start, a_step, a_busy, a_done, a_timeout;
    logic [31:0] a_count;
    logic [2:0]  a_state;
    logic        b_start, b_step, b_busy, b_done, b_timeout;
    logic [31:0] b_count;
    logic [2:0]  b_state;
    logic        c_start, c_step, c_busy, c_done, c_timeout;
    logic [2:0]  c_count;
    logic [2:0]  c_state;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_run_controller #(.CNT_WIDTH(32), .MAX_CYCLES(64)) u_a (
        .i_clock(clk), .i_reset(rst_n), .i_mode(mode), .i_run_cmd(run_cmd),
        .i_step_cmd(step_cmd), .i_halt_wb(halt), .i_clear(clr),
        .o_start(a_start), .o_step(a_step), .o_busy(a_busy), .o_done(a_done),
        .o_timeout(a_timeout), .o_cycle_count(a_count), .o_state(a_state)
    );

    pipeline_run_controller #(.CNT_WIDTH(32), .MAX_CYCLES(8)) u_b (
        .i_clock(clk), .i_reset(rst_n), .i_mode(mode), .i_run_cmd(run_cmd),
        .i_step_cmd(step_cmd), .i_halt_wb(halt), .i_clear(clr),
        .o_start(b_start), .o_step(b_step), .o_busy(b_busy), .o_done(b_done),
        .o_timeout(b_timeout), .o_cycle_count(b_count), .o_state(b_state)
    );

    pipeline_run_controller #(.CNT_WIDTH(3), .MAX_CYCLES(8)) u_c (
        .i_clock(clk), .i_reset(rst_n), .i_mode(mode), .i_run_cmd(run_cmd),
        .i_step_cmd(step_cmd), .i_halt_wb(halt), .i_clear(clr),
        .o_start(c_start), .o_step(c_step), .o_busy(c_busy), .o_done(c_done),
        .o_timeout(c_timeout), .o_cycle_count(c_count), .o_state(c_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a session is either free-running, waiting for a step, pulsing, or finished.
    longint m_max [3] = '{64, 8, 8};
    longint m_sat [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 7};
    bit     m_run [3];
    bit     m_wait[3];
    bit     m_pulse[3];
    bit     m_fin [3];
    bit     m_to  [3];
    longint m_cnt [3];
    bit     m_prev;

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit     adv, idle, rise, hit;
            longint nc;
            adv  = m_run[k] | m_pulse[k];
            idle = !(m_run[k] | m_wait[k] | m_pulse[k] | m_fin[k]);
            rise = step_cmd & ~m_prev;
            hit  = (m_cnt[k] == m_max[k] - 1);
            nc   = m_cnt[k];
            if (adv && m_cnt[k] < m_sat[k]) nc = m_cnt[k] + 1;
            if (!rst_n) begin
                m_run[k] = 0; m_wait[k] = 0; m_pulse[k] = 0; m_fin[k] = 0; m_to[k] = 0;
                nc = 0;
            end else if (clr) begin
                m_run[k] = 0; m_wait[k] = 0; m_pulse[k] = 0; m_fin[k] = 0; m_to[k] = 0;
            end else if (idle) begin
                if (run_cmd) begin
                    nc        = 0;
                    m_run[k]  = !mode;
                    m_wait[k] = mode;
                end
            end else if (adv) begin
                if (halt || hit) begin
                    m_run[k] = 0; m_pulse[k] = 0; m_fin[k] = 1;
                    m_to[k]  = !halt;
                end else if (m_pulse[k]) begin
                    m_pulse[k] = 0; m_wait[k] = 1;
                end
            end else if (m_wait[k]) begin
                if (halt) begin
                    m_wait[k] = 0; m_fin[k] = 1;
                end else if (rise) begin
                    m_wait[k] = 0; m_pulse[k] = 1;
                end
            end
            m_cnt[k] = nc;
        end
        m_prev = rst_n ? step_cmd : 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int k, input logic st, input logic sp, input logic bs,
                              input logic dn, input logic to, input logic [2:0] state,
                              input logic [63:0] cnt);
        logic [2:0] es;
        logic       active;
        active = m_run[k] | m_wait[k] | m_pulse[k];
        es = m_fin[k] ? 3'd4 : m_run[k] ? 3'd1 : m_pulse[k] ? 3'd3 : m_wait[k] ? 3'd2 : 3'd0;
        check($sformatf("model%0d state", k), 64'(state), 64'(es));
        check($sformatf("model%0d start", k), 64'(st), 64'(active));
        check($sformatf("model%0d step", k), 64'(sp), 64'(m_run[k] | m_pulse[k]));
        check($sformatf("model%0d busy", k), 64'(bs), 64'(active));
        check($sformatf("model%0d done", k), 64'(dn), 64'(m_fin[k]));
        check($sformatf("model%0d timeout", k), 64'(to), 64'(m_to[k]));
        check($sformatf("model%0d count", k), cnt, m_cnt[k]);
    endtask

    task automatic tick(input bit rst, input bit cl, input bit md, input bit run,
                        input bit stp, input bit hlt);
        rst_n    = rst;
        clr      = cl;
        mode     = md;
        run_cmd  = run;
        step_cmd = stp;
        halt     = hlt;
        @(posedge clk);
        model_step();
        #1;
        check_inst(0, a_start, a_step, a_busy, a_done, a_timeout, a_state, 64'(a_count));
        check_inst(1, b_start, b_step, b_busy, b_done, b_timeout, b_state, 64'(b_count));
        check_inst(2, c_start, c_step, c_busy, c_done, c_timeout, c_state, 64'(c_count));
    endtask

    typedef struct {
        bit         clr, mode, run, step, halt;
        logic [2:0] exp_state;
        logic       exp_step;
        int         exp_count;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 0; clr = 0; mode = 0; run_cmd = 0; step_cmd = 0; halt = 0;

        // Reset state
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 1, 0);
        check("reset state", a_state, 0);
        check("reset start", a_start, 0);
        check("reset count", a_count, 0);

        // Continuous run, halt seen 20 cycles after entry; mode toggling must be ignored
        tick(1, 0, 0, 1, 0, 0);
        check("run entry state", a_state, 1);
        check("run entry step", a_step, 1);
        check("run entry count", a_count, 0);
        for (int i = 0; i < 20; i++) tick(1, 0, i[0], 0, 0, 0);
        check("run mid count", a_count, 20);
        check("run mid state", a_state, 1);
        tick(1, 0, 0, 0, 0, 1);
        check("halt done", a_done, 1);
        check("halt state", a_state, 4);
        check("halt count", a_count, 21);
        check("halt timeout", a_timeout, 0);
        check("halt step", a_step, 0);
        tick(1, 0, 0, 1, 0, 0);
        check("done ignores run", a_state, 4);
        tick(1, 1, 0, 0, 0, 0);
        check("clear idle", a_state, 0);
        check("clear holds count", a_count, 21);

        // Timeout on the budget-8 configuration
        tick(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) tick(1, 0, 0, 0, 0, 0);
        check("pre-timeout state", b_state, 1);
        check("pre-timeout count", b_count, 7);
        tick(1, 0, 0, 0, 0, 0);
        check("timeout state", b_state, 4);
        check("timeout flag", b_timeout, 1);
        check("timeout count", b_count, 8);
        check("saturated count", c_count, 7);
        check("still running", a_state, 1);
        tick(1, 1, 0, 0, 0, 0);
        check("timeout cleared", b_timeout, 0);
        check("timeout clear state", b_state, 0);
        check("timeout clear count", b_count, 8);

        // Step mode, held step, ignored mode change, halt beating a step edge
        vecs = '{
            '{0, 1, 1, 0, 0, 3'd2, 1'b0, 0},
            '{0, 1, 0, 1, 0, 3'd3, 1'b1, 0},
            '{0, 1, 0, 1, 0, 3'd2, 1'b0, 1},
            '{0, 1, 0, 1, 0, 3'd2, 1'b0, 1},
            '{0, 1, 0, 1, 0, 3'd2, 1'b0, 1},
            '{0, 1, 0, 1, 0, 3'd2, 1'b0, 1},
            '{0, 1, 0, 0, 0, 3'd2, 1'b0, 1},
            '{0, 1, 0, 1, 0, 3'd3, 1'b1, 1},
            '{0, 1, 0, 0, 0, 3'd2, 1'b0, 2},
            '{0, 1, 0, 1, 0, 3'd3, 1'b1, 2},
            '{0, 1, 0, 0, 0, 3'd2, 1'b0, 3},
            '{0, 0, 0, 0, 0, 3'd2, 1'b0, 3},
            '{0, 0, 0, 1, 1, 3'd4, 1'b0, 3},
            '{0, 0, 1, 0, 0, 3'd4, 1'b0, 3},
            '{1, 0, 0, 0, 0, 3'd0, 1'b0, 3}
        };
        foreach (vecs[i]) begin
            tick(1, vecs[i].clr, vecs[i].mode, vecs[i].run, vecs[i].step, vecs[i].halt);
            check($sformatf("vec%0d state", i), a_state, vecs[i].exp_state);
            check($sformatf("vec%0d step", i), a_step, vecs[i].exp_step);
            check($sformatf("vec%0d count", i), a_count, vecs[i].exp_count);
        end

        // Reset asserted mid-run
        tick(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0, 0);
        check("midrun count", a_count, 5);
        tick(0, 0, 0, 0, 0, 0);
        check("midrun reset state", a_state, 0);
        check("midrun reset count", a_count, 0);
        check("midrun reset start", a_start, 0);
        tick(1, 0, 0, 1, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        check("restart count", a_count, 1);
        tick(1, 1, 0, 0, 0, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(199) != 0), ($urandom_range(49) == 0), 1'($urandom_range(1)),
                 ($urandom_range(7) == 0), 1'($urandom_range(1)), ($urandom_range(39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_run_controller.md
Name: pipeline_run_controller

Overview:
Sequences the MIPS pipeline registers by generating the shared start and step enables consumed by every stage register (IF_ID, ID_EX, EX_MEM, MEM_WB). Supports continuous run and debug single-step modes. Stops the pipeline when the halt marker reaches write-back or a cycle budget expires. Keeps a count of executed pipeline advances for the debug unit.

Parameters:
CNT_WIDTH, 32, width of the advance counter.
MAX_CYCLES, 1024, advance budget per run; reaching it forces the timeout stop.

Ports:
i_clock  in  1  system clock, rising edge.
i_reset  in  1  synchronous, active-low reset.
i_mode  in  1  0 = continuous, 1 = single-step; sampled only in IDLE.
i_run_cmd  in  1  start request, level-sampled; honoured only in IDLE.
i_step_cmd  in  1  step request; a rising edge produces one advance.
i_halt_wb  in  1  halt marker is valid in write-back (from MEM_WB o_halt).
i_clear  in  1  abort/clear; returns the controller to IDLE from any state.
o_start  out  1  pipeline enabled, drives i_start of the stage registers.
o_step  out  1  advance enable, drives i_step of the stage registers.
o_busy  out  1  high in RUN, STEP_WAIT or STEP_PULSE.
o_done  out  1  high in DONE.
o_timeout  out  1  set when DONE was entered by budget expiry; cleared on leaving DONE.
o_cycle_count  out  CNT_WIDTH  number of cycles with o_step=1 since the last run start.
o_state  out  3  encoded state: IDLE=0, RUN=1, STEP_WAIT=2, STEP_PULSE=3, DONE=4.

Behaviour:
- Reset (i_reset=0 at a clock edge): state IDLE. o_start, o_step, o_busy, o_done and o_timeout all 0. o_cycle_count 0. Step-edge history register 0.
- Outputs are Moore, decoded from the registered state. o_start=1 in RUN, STEP_WAIT and STEP_PULSE. o_step=1 only in RUN and STEP_PULSE.
- Step edge: step_rise = i_step_cmd & ~step_prev. step_prev is registered every cycle in every state.
- Transition priority each cycle, highest first: reset, i_clear, i_halt_wb, timeout, commands.
- IDLE:
  - i_run_cmd=1 moves to RUN if i_mode=0, otherwise to STEP_WAIT.
  - o_cycle_count clears to 0 on this transition.
- RUN:
  - o_cycle_count increments every cycle.
  - i_halt_wb=1 moves to DONE.
  - Else, if o_cycle_count==MAX_CYCLES-1, moves to DONE with o_timeout set.
  - The cycle in which either condition is seen is itself an advance, so exactly one extra advance occurs.
- STEP_WAIT:
  - No advance.
  - i_halt_wb=1 moves to DONE; this wins over step_rise in the same cycle.
  - Else step_rise moves to STEP_PULSE.
- STEP_PULSE:
  - Exactly one cycle with o_step=1; o_cycle_count increments.
  - Next state: DONE if i_halt_wb=1 or count==MAX_CYCLES-1 (timeout set for the latter); otherwise STEP_WAIT.
  - Step edges arriving during STEP_PULSE are dropped, not queued.
- DONE:
  - o_start=0, o_step=0; o_cycle_count holds.
  - i_run_cmd is ignored; only i_clear leaves, moving to IDLE.
- i_clear in any state: next state IDLE, o_timeout cleared. o_cycle_count holds until the next run start, so debug can read it.
- i_mode changes outside IDLE have no effect.
- Counter: increments only when o_step=1 and saturates at all-ones. MAX_CYCLES must be ≤ 2^CNT_WIDTH.
- Reset asserted mid-run: IDLE on the next edge regardless of state. The pipeline stage registers reset on the same edge.

Test Plan:
- Continuous run: i_mode=0, i_run_cmd pulse, i_halt_wb raised 20 cycles after RUN entry -> o_step high for 21 cycles, then DONE, o_done=1, o_cycle_count=21, o_timeout=0.
- Step mode: i_mode=1, run, then 3 rising edges of i_step_cmd (one held high for 5 cycles) -> exactly 3 single-cycle o_step pulses, o_cycle_count=3, state STEP_WAIT.
- Simultaneous events: in STEP_WAIT, i_halt_wb=1 and step_rise in the same cycle -> DONE, no o_step pulse, count unchanged.
- Timeout: MAX_CYCLES=8, continuous run, no halt -> 8 advances, DONE with o_timeout=1. i_clear -> IDLE, o_timeout=0, o_cycle_count=8.
- Mid-run reset: i_reset=0 during RUN at count=5 -> next edge IDLE, all outputs 0, count 0. A later run restarts counting from 0.
- Ignored commands: i_run_cmd during DONE and i_mode toggled during RUN -> no state change, behaviour unaffected.
